// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_pkg
// Description : Shared Q8.24 fixed-point scalar/vector types, constants and
//               the sphere table entry used by the ray-march scene query path.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_pkg;

    typedef logic signed [31:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef struct packed {
        vec3  center;
        fp    radius;
        logic enable;
    } sphere_t;

    localparam fp FP_ONE       = 32'sh0100_0000;
    localparam fp FP_MAX       = 32'sh7FFF_FFFF;
    localparam fp SURFACE_DIST = 32'sh0002_8F5C;

endpackage
`default_nettype wire

// File: rtl/fp_sqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_sqrt_iter
// Description : Digit-by-digit integer square root, 64-bit radicand to 32-bit
//               root, one root bit per cycle. The radicand loads on i_start;
//               o_done pulses 32 cycles later with o_root valid that cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_sqrt_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic [63:0] i_radicand,
    output logic        o_done,
    output logic [31:0] o_root
);

    logic [63:0] r_rad;
    logic [33:0] r_rem;
    logic [31:0] r_root;
    logic [4:0]  r_cnt;
    logic        r_busy;

    logic [35:0] w_rem_shift;
    logic [35:0] w_trial;
    logic        w_fit;
    logic [33:0] w_rem_next;
    logic [31:0] w_root_next;

    // The final (32nd) bit is resolved combinationally in the done cycle.
    always_comb begin
        w_rem_shift = {r_rem, r_rad[63:62]};
        w_trial     = {2'b00, r_root, 2'b01};
        w_fit       = (w_rem_shift >= w_trial);
        w_rem_next  = w_fit ? 34'(w_rem_shift - w_trial) : w_rem_shift[33:0];
        w_root_next = {r_root[30:0], w_fit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rad  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_rad  <= i_radicand;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == 5'd31) begin
                r_busy <= 1'b0;
            end else begin
                r_rad  <= {r_rad[61:0], 2'b00};
                r_rem  <= w_rem_next;
                r_root <= w_root_next;
                r_cnt  <= r_cnt + 5'd1;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == 5'd31);
    assign o_root = w_root_next;

endmodule
`default_nettype wire

// File: rtl/scene_distance_responder.sv
`default_nettype none
// ============================================================================
// Module      : scene_distance_responder
// Description : Scene-query responder: minimum signed distance over a writable
//               sphere table, one sphere per 35-cycle slot. Optional ground
//               plane (y=0) enabled by macro SCENE_GROUND_PLANE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module scene_distance_responder
    import vector_pkg::*;
#(
    parameter int NUM_SPHERES = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            query_valid,
    output logic                                            query_ready,
    input  logic [95:0]                                     query_pos,
    output logic                                            resp_valid,
    input  logic                                            resp_ready,
    output logic [31:0]                                     resp_dist,
    output logic [$clog2(NUM_SPHERES+1)-1:0]                resp_id,
    input  logic                                            cfg_we,
    input  logic [((NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1)-1:0] cfg_addr,
    input  logic [95:0]                                     cfg_center,
    input  logic [31:0]                                     cfg_radius,
    input  logic                                            cfg_enable
);

    localparam int c_IW    = $clog2(NUM_SPHERES + 1);
    localparam int c_AW    = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1;
    localparam int c_DEPTH = 1 << c_AW;
    localparam logic [c_IW-1:0] c_NONE = c_IW'(NUM_SPHERES);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(NUM_SPHERES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIFF = 3'd1,
        S_SQR  = 3'd2,
        S_ROOT = 3'd3,
        S_ACC  = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t              r_state, w_next;
    sphere_t             r_table [c_DEPTH];
    vec3                 r_pos;
    logic [c_AW-1:0]     r_idx;
    fp                   r_acc_dist;
    logic [c_IW-1:0]     r_acc_id;
    logic signed [32:0]  r_dx, r_dy, r_dz;
    logic                r_ovf;
    logic [31:0]         r_root;
    logic                r_resp_valid;
    fp                   r_resp_dist;
    logic [c_IW-1:0]     r_resp_id;

    vec3                 w_query;
    sphere_t             w_sph;
    fp                   w_acc_init;
    logic signed [65:0]  w_sqx, w_sqy, w_sqz;
    logic [67:0]         w_sum;
    logic                w_ovf;
    logic [33:0]         w_diff;
    fp                   w_sd;
    logic                w_take;
    logic                w_last;
    logic                w_addr_ok;
    logic                w_query_ready;
    logic                w_sqrt_start;
    logic                w_sqrt_done;
    logic [31:0]         w_sqrt_root;

    assign w_query   = vec3'(query_pos);
    assign w_sph     = r_table[r_idx];
    assign w_last    = (r_idx == c_LAST);
    assign w_addr_ok = (32'(cfg_addr) < NUM_SPHERES);

`ifdef SCENE_GROUND_PLANE_EN
    assign w_acc_init = w_query.y;
`else
    assign w_acc_init = FP_MAX;
`endif

    always_comb begin
        w_sqx = 66'(r_dx) * 66'(r_dx);
        w_sqy = 66'(r_dy) * 66'(r_dy);
        w_sqz = 66'(r_dz) * 66'(r_dz);
        w_sum = {2'b00, w_sqx} + {2'b00, w_sqy} + {2'b00, w_sqz};
        w_ovf = |w_sum[67:62];
    end

    // root is unsigned and radius non-negative, but saturate both ends anyway.
    always_comb begin
        w_diff = {2'b00, r_root} - {{2{w_sph.radius[31]}}, w_sph.radius};
        if (r_ovf)
            w_sd = FP_MAX;
        else if (!w_diff[33] && (|w_diff[32:31]))
            w_sd = FP_MAX;
        else if (w_diff[33] && !(&w_diff[32:31]))
            w_sd = 32'sh8000_0000;
        else
            w_sd = w_diff[31:0];
    end

    // A sphere equal to the plane still wins: the plane only holds id NONE.
`ifdef SCENE_GROUND_PLANE_EN
    assign w_take = w_sph.enable &&
                    ((w_sd < r_acc_dist) || ((w_sd == r_acc_dist) && (r_acc_id == c_NONE)));
`else
    assign w_take = w_sph.enable && (w_sd < r_acc_dist);
`endif

    fp_sqrt_iter u_sqrt (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_sqrt_start),
        .i_radicand ({2'b00, w_sum[61:0]}),
        .o_done     (w_sqrt_done),
        .o_root     (w_sqrt_root)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_query_ready = 1'b0;
        w_sqrt_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_query_ready = 1'b1;
                if (query_valid) w_next = S_DIFF;
            end
            S_DIFF: w_next = S_SQR;
            S_SQR: begin
                w_sqrt_start = 1'b1;
                w_next       = S_ROOT;
            end
            S_ROOT: if (w_sqrt_done) w_next = S_ACC;
            S_ACC:  w_next = w_last ? S_RESP : S_DIFF;
            S_RESP: if (r_resp_valid && resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_table[i] <= '0;
        end else if ((r_state == S_IDLE) && cfg_we && w_addr_ok) begin
            r_table[cfg_addr] <= sphere_t'({cfg_center, cfg_radius, cfg_enable});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pos        <= '0;
            r_idx        <= '0;
            r_acc_dist   <= FP_MAX;
            r_acc_id     <= c_NONE;
            r_dx         <= '0;
            r_dy         <= '0;
            r_dz         <= '0;
            r_ovf        <= 1'b0;
            r_root       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_dist  <= FP_MAX;
            r_resp_id    <= c_NONE;
        end else begin
            case (r_state)
                S_IDLE: if (query_valid) begin
                    r_pos      <= w_query;
                    r_acc_dist <= w_acc_init;
                    r_acc_id   <= c_NONE;
                    r_idx      <= '0;
                end
                S_DIFF: begin
                    r_dx <= {r_pos.x[31], r_pos.x} - {w_sph.center.x[31], w_sph.center.x};
                    r_dy <= {r_pos.y[31], r_pos.y} - {w_sph.center.y[31], w_sph.center.y};
                    r_dz <= {r_pos.z[31], r_pos.z} - {w_sph.center.z[31], w_sph.center.z};
                end
                S_SQR:  r_ovf <= w_ovf;
                S_ROOT: if (w_sqrt_done) r_root <= w_sqrt_root;
                S_ACC: begin
                    if (w_take) begin
                        r_acc_dist <= w_sd;
                        r_acc_id   <= c_IW'(r_idx);
                    end
                    if (!w_last) r_idx <= r_idx + c_AW'(1);
                end
                // First RESP cycle registers the result; valid follows.
                S_RESP: begin
                    if (!r_resp_valid) begin
                        r_resp_valid <= 1'b1;
                        r_resp_dist  <= r_acc_dist;
                        r_resp_id    <= r_acc_id;
                    end else if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign query_ready = w_query_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_dist   = r_resp_dist;
    assign resp_id     = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_scene_distance_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scene_distance_responder
// Description : Self-checking bench: directed table, multi-cycle corner cases
//               and randomized scenes against a behavioural distance model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scene_distance_responder;

    localparam int N     = 4;
    localparam int FPMAX = 32'h7FFF_FFFF;
    localparam int LAT   = 35 * N + 1;
`ifdef SCENE_GROUND_PLANE_EN
    localparam bit PLANE = 1'b1;
`else
    localparam bit PLANE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        query_valid, query_ready, resp_valid, resp_ready;
    logic [95:0] query_pos, cfg_center;
    logic [31:0] resp_dist, cfg_radius;
    logic [2:0]  resp_id;
    logic        cfg_we, cfg_enable;
    logic [1:0]  cfg_addr;

    int n_pass = 0;
    int n_total = 0;

    int m_cx[N], m_cy[N], m_cz[N], m_r[N];
    bit m_en[N];

    always #5 clk = ~clk;

    scene_distance_responder #(.NUM_SPHERES(N)) dut (
        .clk(clk), .rst(rst),
        .query_valid(query_valid), .query_ready(query_ready), .query_pos(query_pos),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dist(resp_dist), .resp_id(resp_id),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_center(cfg_center),
        .cfg_radius(cfg_radius), .cfg_enable(cfg_enable)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic longint isqrt(input longint unsigned n);
        longint r;
        r = longint'($sqrt(real'(n)));
        while (r > 0 && longint'(r * r) > longint'(n)) r--;
        while (longint'((r + 1) * (r + 1)) <= longint'(n)) r++;
        return r;
    endfunction

    function automatic longint sphere_sd(input int qx, qy, qz, input int i);
        longint d[3];
        longint unsigned a[3];
        logic [127:0] s;
        longint v;
        d[0] = longint'(qx) - longint'(m_cx[i]);
        d[1] = longint'(qy) - longint'(m_cy[i]);
        d[2] = longint'(qz) - longint'(m_cz[i]);
        s = '0;
        for (int k = 0; k < 3; k++) begin
            a[k] = (d[k] < 0) ? longint'(-d[k]) : d[k];
            s = s + 128'(a[k]) * 128'(a[k]);
        end
        if (s >= (128'd1 << 62)) return longint'(FPMAX);
        v = isqrt(s[63:0]) - longint'(m_r[i]);
        if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
        if (v < -64'sh8000_0000) v = -64'sh8000_0000;
        return v;
    endfunction

    function automatic void model(input int qx, qy, qz, output int d, output int id);
        longint best, sd;
        best = PLANE ? longint'(qy) : longint'(FPMAX);
        id = N;
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                sd = sphere_sd(qx, qy, qz, i);
                if (sd < best || (PLANE && id == N && sd == best)) begin
                    best = sd;
                    id = i;
                end
            end
        end
        d = int'(best);
    endfunction

    task automatic cfg_write(input int a, cx, cy, cz, r, input bit en);
        cfg_we = 1'b1; cfg_addr = a[1:0]; cfg_center = {cx, cy, cz};
        cfg_radius = r; cfg_enable = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_cx[a] = cx; m_cy[a] = cy; m_cz[a] = cz; m_r[a] = r; m_en[a] = en;
    endtask

    task automatic clear_scene();
        for (int i = 0; i < N; i++) cfg_write(i, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic issue(input int qx, qy, qz);
        int n;
        n = 0;
        query_pos = {qx, qy, qz};
        query_valid = 1'b1;
        while (!query_ready && n < 1000) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        query_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!resp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take_resp(output int d, output int id);
        d = resp_dist;
        id = int'(resp_id);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_query(input int qx, qy, qz, output int d, output int id, output int lat);
        issue(qx, qy, qz);
        wait_valid(lat);
        take_resp(d, id);
    endtask

    typedef struct {
        bit do_cfg; int addr; int cx, cy, cz, r; bit en;
        int qx, qy, qz; int exp_dist; int exp_id;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int d, id, lat, ed, eid, hd, hid;
        bit ok, seen;

        rst = 1'b1; query_valid = 1'b0; resp_ready = 1'b0; query_pos = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_center = '0; cfg_radius = '0; cfg_enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_en[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_query_ready", query_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_dist", resp_dist, FPMAX);
        check("reset_resp_id", resp_id, N);

`ifndef SCENE_GROUND_PLANE_EN
        tbl[0] = '{1, 0, 0, 0, 32'h0500_0000, 32'h0100_0000, 1, 0, 0, 0, 32'h0400_0000, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0500_0000, 32'hFF00_0000, 0};
        tbl[2] = '{1, 0, 0, 0, 32'h0300_0000, 32'h0100_0000, 1, 0, 0, 0, 32'h0200_0000, 0};
        tbl[3] = '{1, 1, 0, 0, 32'hFD00_0000, 32'h0100_0000, 1, 0, 0, 0, 32'h0200_0000, 0};
        tbl[4] = '{1, 2, 32'h0300_0000, 32'h0400_0000, 0, 32'h0080_0000, 1, 0, 0, 0, 32'h0200_0000, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 32'h0300_0000, 32'h0400_0000, 32'h0100_0000, 32'h0080_0000, 2};
        tbl[6] = '{1, 0, 0, 0, 32'h0300_0000, 32'h0100_0000, 0, 0, 0, 0, 32'h0200_0000, 1};
        tbl[7] = '{1, 1, 0, 0, 32'hFD00_0000, 32'h0100_0000, 0, 0, 0, 0, 32'h0480_0000, 2};
        tbl[8] = '{1, 2, 32'h0300_0000, 32'h0400_0000, 0, 32'h0080_0000, 0, 0, 0, 0, FPMAX, N};
        tbl[9] = '{1, 3, 0, 0, 0, 32'h0200_0000, 1, 0, 0, 32'h0080_0000, 32'hFE80_0000, 3};
        for (int t = 0; t < 10; t++) begin
            if (tbl[t].do_cfg)
                cfg_write(tbl[t].addr, tbl[t].cx, tbl[t].cy, tbl[t].cz, tbl[t].r, tbl[t].en);
            run_query(tbl[t].qx, tbl[t].qy, tbl[t].qz, d, id, lat);
            check($sformatf("tbl%0d_dist", t), d, tbl[t].exp_dist);
            check($sformatf("tbl%0d_id", t), id, tbl[t].exp_id);
            check($sformatf("tbl%0d_latency", t), lat, LAT);
        end
`endif

        // cfg write and query accepted on the same edge: query sees new entry
        clear_scene();
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_center = {32'd0, 32'd0, 32'h0200_0000};
        cfg_radius = 32'h0100_0000; cfg_enable = 1'b1;
        query_pos = '0; query_valid = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; query_valid = 1'b0;
        m_cz[1] = 32'h0200_0000; m_r[1] = 32'h0100_0000; m_en[1] = 1'b1;
        wait_valid(lat);
        take_resp(d, id);
        model(0, 0, 0, ed, eid);
        check("samecycle_dist", d, ed);
        check("samecycle_id", id, eid);

        // Hold the response: outputs stable, no new query accepted
        issue(0, 0, 0);
        wait_valid(lat);
        hd = resp_dist; hid = int'(resp_id);
        ok = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b1 || resp_dist !== hd || int'(resp_id) != hid || query_ready !== 1'b0)
                ok = 1'b0;
        end
        check("hold_stable", ok, 1);
        take_resp(d, id);
        check("hold_dist", d, ed);
        check("b2b_query_ready", query_ready, 1);

        // Write during a busy query must be dropped
        clear_scene();
        cfg_write(3, 0, 0, 0, 32'h0200_0000, 1'b1);
        issue(0, 0, 32'h0080_0000);
        repeat (5) @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_addr = 2'd3; cfg_center = '0; cfg_radius = '0; cfg_enable = 1'b0;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        wait_valid(lat);
        take_resp(d, id);
        run_query(0, 0, 32'h0080_0000, d, id, lat);
        model(0, 0, 32'h0080_0000, ed, eid);
        check("dropped_write_dist", d, ed);
        check("dropped_write_id", id, eid);

        // Radicand overflow: distance beyond range is treated as FP_MAX
        cfg_write(3, 0, 0, 0, 0, 1'b0);
        cfg_write(0, 32'h8000_0000, 0, 0, 0, 1'b1);
        run_query(32'h7FFF_FFFF, 0, 0, d, id, lat);
        model(32'h7FFF_FFFF, 0, 0, ed, eid);
        check("overflow_dist", d, ed);
        check("overflow_id", id, eid);

        // Randomized scenes
        for (int t = 0; t < 16; t++) begin
            int qx, qy, qz;
            for (int s = 0; s < N; s++)
                if ($urandom_range(0, 1) == 1)
                    cfg_write(s, int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000,
                                 int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000,
                                 int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000,
                                 int'($urandom_range(0, 32'h03FF_FFFF)),
                                 $urandom_range(0, 3) != 0);
            qx = int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
            qy = int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
            qz = int'($urandom_range(0, 32'h0FFF_FFFF)) - 32'h0800_0000;
            run_query(qx, qy, qz, d, id, lat);
            model(qx, qy, qz, ed, eid);
            check($sformatf("rand%0d_dist", t), d, ed);
            check($sformatf("rand%0d_id", t), id, eid);
            check($sformatf("rand%0d_latency", t), lat, LAT);
        end

        // Reset during ROOT aborts the query and clears the table
        cfg_write(0, 0, 0, 32'h0300_0000, 32'h0100_0000, 1'b1);
        issue(0, 0, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_cx[i] = 0; m_cy[i] = 0; m_cz[i] = 0; m_r[i] = 0; m_en[i] = 1'b0;
        end
        check("midreset_query_ready", query_ready, 1);
        check("midreset_resp_valid", resp_valid, 0);
        seen = 1'b0;
        repeat (200) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check("midreset_no_response", seen, 0);
        run_query(0, 0, 0, d, id, lat);
        model(0, 0, 0, ed, eid);
        check("midreset_cleared_dist", d, ed);
        check("midreset_cleared_id", id, eid);

`ifdef SCENE_GROUND_PLANE_EN
        clear_scene();
        cfg_write(0, 0, 0, 32'h6400_0000, 32'h0100_0000, 1'b1);
        run_query(0, 32'h0080_0000, 0, d, id, lat);
        check("plane_dist", d, 32'h0080_0000);
        check("plane_id", id, N);
        check("plane_latency", lat, LAT);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
